sync_fifo_flex: RTL and testbench
=================================

Name: sync_fifo_flex

Overview:
- Single-clock, parametrised FIFO; successor to the dual-clock pointer FIFO for intra-domain buffering.
- Adds the following over the previous block:
  - DEPTH need not be a power of two.
  - Occupancy count output.
  - Programmable almost-full and almost-empty thresholds.
  - Selectable show-ahead (FWFT) or registered-read mode.
  - Synchronous flush.
  - Sticky overflow and underflow error flags.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of storage entries (>=2, any integer).
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).
- FWFT, 1, 1 = show-ahead read; 0 = registered read with 1-cycle latency.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous flush; same effect as rst on pointers, count and flags.
- wdata  in  WIDTH  write data.
- wen  in  1  write request.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- ren  in  1  read request / pop.
- rdata  out  WIDTH  read data.
- rvalid  out  1  rdata holds a valid popped/head word.
- empty  out  1  count == 0.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset: on a posedge with rst=1, clear wr_idx, rd_idx, count, overflow, underflow, rvalid and rdata (FWFT=0 register) to 0. Consequently empty=1, almost_empty=1, full=0, almost_full=0. Memory array is not reset.
- Priority: rst > clr > normal operation. With clr=1 and rst=0: pointers, count, rvalid and sticky flags go to 0. wen/ren that cycle are ignored and are not counted as overflow/underflow. FWFT=0 rdata holds its last value.
- Write accept: wa = wen & !full (state before the edge). On wa, mem[wr_idx] <= wdata and wr_idx advances; wrap from DEPTH-1 to 0 by explicit compare, not by bit truncation.
- Read accept: ra = ren & !empty (state before the edge). On ra, rd_idx advances with the same wrap rule.
- No pass-through:
  - A write while full is rejected even if a read is accepted in the same cycle.
  - A read while empty is rejected even if a write is accepted in the same cycle.
- Count update: count_next = count + wa - ra. Simultaneous wa and ra leaves count unchanged.
- Status flags: full, empty, almost_full and almost_empty are combinational decodes of the registered count only. They change only in the cycle after the causing edge and never combinationally on wen/ren.
- Sticky errors: overflow <= 1 on wen & full; underflow <= 1 on ren & empty. Both hold until rst or clr.
- FWFT=1:
  - rdata = mem[rd_idx] when !empty, else 0.
  - rvalid = !empty.
  - A word written at edge N appears on rdata after edge N (empty was 1, count becomes 1).
  - ren pops the displayed word; the next word is shown after the edge.
- FWFT=0:
  - On ra, rdata <= mem[rd_idx] and rvalid <= 1.
  - Otherwise rvalid <= 0 and rdata holds.
  - Read latency is 1 cycle from the accepting edge.
- Data ordering is strict FIFO across all wraps. Write-then-read latency is unaffected by DEPTH.

Test Plan:
- DEPTH=5, FWFT=1, after reset: write 0x11..0x15 on 5 consecutive cycles -> count 1..5. full=1 after the 5th edge. almost_full=1 from count=3 (AF_THRESH=3). A 6th write of 0x16 sets overflow=1, count stays 5. Reading 5 words returns 0x11..0x15 in order; then empty=1 and almost_empty=1.
- DEPTH=5: repeat 12 write/read pairs with 2 entries resident -> both indices wrap through 4->0 at least twice. Data matches in order; count stays 2.
- Empty with wen=1, ren=1 on the same edge -> write accepted, read rejected. count=1, underflow=1. FWFT=1: rdata = written word next cycle.
- Full (count=DEPTH) with wen=1, ren=1 -> read accepted, write rejected. count=DEPTH-1, overflow=1, head word popped.
- FWFT=0, DEPTH=16: write 0xA5, then ren for 1 cycle -> rvalid=1 and rdata=0xA5 exactly one cycle after the accepting edge. rvalid=0 the following cycle.
- With count=3 and both sticky flags set: assert clr with wen=1 -> count=0, empty=1, overflow=0, underflow=0, write discarded. Separately, asserting rst mid-stream gives all outputs at their reset values after the edge.

Source files
------------

// File: rtl/sync_fifo_flex.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_flex
//  Purpose  : Single-clock FIFO with arbitrary depth, occupancy count,
//             almost-full/empty thresholds, FWFT or registered read, flush,
//             and sticky overflow/underflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo_flex #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       wen,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       ren,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rvalid,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW-1:0] c_LAST_IDX  = c_AW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_FULL_CNT  = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_AF_CNT    = c_CW'(AF_THRESH);
    localparam logic [c_CW-1:0] c_AE_CNT    = c_CW'(AE_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_idx;
    logic [c_AW-1:0]  r_rd_idx;
    logic [c_CW-1:0]  r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wa;
    logic w_ra;

    // Flags decode only the registered count, never the live requests.
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_wa    = wen & ~w_full;
    assign w_ra    = ren & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_wa && !rst && !clr) begin
            r_mem[r_wr_idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wa) begin
                r_wr_idx <= (r_wr_idx == c_LAST_IDX) ? '0 : r_wr_idx + 1'b1;
            end
            if (w_ra) begin
                r_rd_idx <= (r_rd_idx == c_LAST_IDX) ? '0 : r_rd_idx + 1'b1;
            end
            case ({w_wa, w_ra})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (wen && w_full) begin
                r_overflow <= 1'b1;
            end
            if (ren && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata  = w_empty ? '0 : r_mem[r_rd_idx];
            assign rvalid = ~w_empty;
        end else begin : g_reg_read
            logic [WIDTH-1:0] r_rdata;
            logic             r_rvalid;

            // Flush drops the valid strobe but keeps the last popped word.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else if (clr) begin
                    r_rvalid <= 1'b0;
                end else if (w_ra) begin
                    r_rdata  <= r_mem[r_rd_idx];
                    r_rvalid <= 1'b1;
                end else begin
                    r_rvalid <= 1'b0;
                end
            end

            assign rdata  = r_rdata;
            assign rvalid = r_rvalid;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AF_CNT);
    assign almost_empty = (r_count <= c_AE_CNT);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_flex
//  Purpose  : Scoreboard bench for sync_fifo_flex, one FWFT and one
//             registered-read instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo_flex;

    logic       clk;
    logic       rst;

    logic       a_clr, a_wen, a_ren;
    logic [7:0] a_wdata, a_rdata;
    logic       a_full, a_af, a_empty, a_ae, a_rvalid, a_ov, a_un;
    logic [2:0] a_count;

    logic       b_clr, b_wen, b_ren;
    logic [7:0] b_wdata, b_rdata;
    logic       b_full, b_af, b_empty, b_ae, b_rvalid, b_ov, b_un;
    logic [4:0] b_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    sync_fifo_flex #(.WIDTH(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(2), .FWFT(1)) u_dut_a (
        .clk(clk), .rst(rst), .clr(a_clr), .wdata(a_wdata), .wen(a_wen),
        .full(a_full), .almost_full(a_af), .ren(a_ren), .rdata(a_rdata),
        .rvalid(a_rvalid), .empty(a_empty), .almost_empty(a_ae),
        .count(a_count), .overflow(a_ov), .underflow(a_un)
    );

    sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_dut_b (
        .clk(clk), .rst(rst), .clr(b_clr), .wdata(b_wdata), .wen(b_wen),
        .full(b_full), .almost_full(b_af), .ren(b_ren), .rdata(b_rdata),
        .rvalid(b_rvalid), .empty(b_empty), .almost_empty(b_ae),
        .count(b_count), .overflow(b_ov), .underflow(b_un)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitors: FWFT pops are observed on ren&rvalid, registered reads on rvalid.
    always @(negedge clk) begin
        if (!rst && !a_clr && a_ren && a_rvalid) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_pop", {24'd0, a_rdata}, 32'hFFFF_FFFF);
            end else begin
                chk("a_pop_data", {24'd0, a_rdata}, {24'd0, q_a.pop_front()});
            end
        end
        if (!rst && b_rvalid) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_rvalid", {24'd0, b_rdata}, 32'hFFFF_FFFF);
            end else begin
                chk("b_read_data", {24'd0, b_rdata}, {24'd0, q_b.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1;
        a_clr = 1'b0; a_wen = 1'b0; a_ren = 1'b0; a_wdata = 8'h00;
        b_clr = 1'b0; b_wen = 1'b0; b_ren = 1'b0; b_wdata = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count", a_count, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_ae", a_ae, 1);
        chk("rst_full", a_full, 0);
        chk("rst_af", a_af, 0);
        chk("rst_ov_un", {a_ov, a_un}, 0);
        chk("rst_a_rvalid_rdata", {a_rvalid, a_rdata}, 0);
        chk("rst_b_rvalid_rdata", {b_rvalid, b_rdata}, 0);

        // Fill DEPTH=5 instance.
        for (int i = 0; i < 5; i++) begin
            a_wen = 1'b1; a_wdata = 8'h11 + 8'(i);
            tick();
            chk("fill_count", a_count, i + 1);
            chk("fill_af", a_af, (i + 1 >= 3) ? 1 : 0);
            chk("fill_full", a_full, (i == 4) ? 1 : 0);
        end
        a_wdata = 8'h16;
        tick();
        chk("ovf_flag", a_ov, 1);
        chk("ovf_count", a_count, 5);
        a_wen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            q_a.push_back(8'h11 + 8'(i));
            a_ren = 1'b1;
            tick();
        end
        a_ren = 1'b0;
        chk("drain_empty", a_empty, 1);
        chk("drain_ae", a_ae, 1);
        chk("drain_count", a_count, 0);
        chk("drain_no_un", a_un, 0);

        // Two resident entries, then 12 simultaneous write/read pairs.
        a_wen = 1'b1;
        a_wdata = 8'h20; tick();
        a_wdata = 8'h21; tick();
        for (int i = 0; i < 12; i++) begin
            a_wdata = 8'h22 + 8'(i);
            a_ren = 1'b1;
            q_a.push_back(8'h20 + 8'(i));
            tick();
            chk("wrap_count", a_count, 2);
        end
        a_wen = 1'b0;
        q_a.push_back(8'h2C); tick();
        q_a.push_back(8'h2D); tick();
        a_ren = 1'b0;
        chk("wrap_empty", a_empty, 1);

        // Empty with write+read: read rejected.
        a_wen = 1'b1; a_ren = 1'b1; a_wdata = 8'h33;
        tick();
        a_wen = 1'b0; a_ren = 1'b0;
        chk("empty_wr_count", a_count, 1);
        chk("empty_wr_un", a_un, 1);
        chk("empty_wr_rdata", a_rdata, 8'h33);
        chk("empty_wr_rvalid", a_rvalid, 1);
        q_a.push_back(8'h33); a_ren = 1'b1; tick(); a_ren = 1'b0;

        // Full with write+read: write rejected, head popped.
        for (int i = 0; i < 5; i++) begin
            a_wen = 1'b1; a_wdata = 8'h41 + 8'(i);
            tick();
        end
        chk("full_before", a_full, 1);
        a_wdata = 8'h46; a_ren = 1'b1; q_a.push_back(8'h41);
        tick();
        a_wen = 1'b0; a_ren = 1'b0;
        chk("full_rw_count", a_count, 4);
        chk("full_rw_ov", a_ov, 1);
        chk("full_rw_head", a_rdata, 8'h42);

        // Flush with count=3 and both sticky flags set.
        q_a.push_back(8'h42); a_ren = 1'b1; tick(); a_ren = 1'b0;
        chk("pre_clr_state", {a_count, a_ov, a_un}, {3'd3, 1'b1, 1'b1});
        a_clr = 1'b1; a_wen = 1'b1; a_wdata = 8'h77;
        tick();
        a_clr = 1'b0;
        chk("clr_count", a_count, 0);
        chk("clr_empty", a_empty, 1);
        chk("clr_flags", {a_ov, a_un}, 0);
        a_wdata = 8'h88;
        tick();
        a_wen = 1'b0;
        chk("clr_discard_head", a_rdata, 8'h88);
        chk("clr_discard_count", a_count, 1);

        // Registered-read instance.
        b_wen = 1'b1; b_wdata = 8'hA5; tick(); b_wen = 1'b0;
        chk("b_wr_count", b_count, 1);
        chk("b_no_rvalid", b_rvalid, 0);
        b_ren = 1'b1; q_b.push_back(8'hA5); tick(); b_ren = 1'b0;
        chk("b_lat_rvalid", b_rvalid, 1);
        chk("b_lat_rdata", b_rdata, 8'hA5);
        tick();
        chk("b_rvalid_drop", b_rvalid, 0);
        chk("b_rdata_hold", b_rdata, 8'hA5);
        b_ren = 1'b1; tick(); b_ren = 1'b0;
        chk("b_underflow", b_un, 1);
        chk("b_empty_read", {b_rvalid, b_rdata}, {1'b0, 8'hA5});
        b_wen = 1'b1;
        b_wdata = 8'h01; tick();
        b_wdata = 8'h02; tick();
        b_wen = 1'b0;
        b_ren = 1'b1;
        q_b.push_back(8'h01); tick();
        q_b.push_back(8'h02); tick();
        b_ren = 1'b0;
        tick();
        chk("b_final_empty", b_empty, 1);

        // Mid-stream reset on the FWFT instance.
        a_wen = 1'b1; a_wdata = 8'h99; tick();
        a_wdata = 8'h9A; rst = 1'b1; tick();
        rst = 1'b0; a_wen = 1'b0;
        chk("mrst_count", a_count, 0);
        chk("mrst_flags", {a_empty, a_ae, a_full, a_af}, 4'b1100);
        chk("mrst_sticky", {a_ov, a_un}, 0);
        chk("mrst_read", {a_rvalid, a_rdata}, 0);

        tick();
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
